// File: rtl/ascon_controller.sv
// ascon_controller: sequencing FSM for an Ascon-128 style encryption datapath.
// Steps through initialization, NB_AD associated-data blocks, NB_PT plaintext
// blocks and finalization, driving the round index and datapath enables.
// Optional feature: define ASCON_CONTROLLER_ABORT_EN to add an abort_i input
// that returns the controller to IDLE from any active state.
module ascon_controller #(
    parameter int unsigned NB_AD = 1,
    parameter int unsigned NB_PT = 4
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       data_valid_i,
`ifdef ASCON_CONTROLLER_ABORT_EN
    input  logic       abort_i,
`endif
    output logic       data_ready_o,
    output logic [3:0] round_o,
    output logic       data_sel_o,
    output logic       en_xor_data_o,
    output logic       en_xor_key_o,
    output logic       en_xor_key_end_o,
    output logic       en_xor_lsb_o,
    output logic       en_reg_state_o,
    output logic       en_cipher_o,
    output logic       en_tag_o,
    output logic       cipher_valid_o,
    output logic       done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_AD,
        S_AD,
        S_WAIT_PT,
        S_PT,
        S_FINAL,
        S_DONE
    } state_t;

    localparam logic [3:0] ROUND_FIRST = 4'd0;
    localparam logic [3:0] ROUND_HALF  = 4'd6;
    localparam logic [3:0] ROUND_LAST  = 4'd11;
    localparam logic [3:0] NB_AD_L     = 4'(NB_AD);
    localparam logic [3:0] NB_PT_L     = 4'(NB_PT);

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [3:0] ad_cnt_q, ad_cnt_d;
    logic [3:0] pt_cnt_q, pt_cnt_d;
    logic       cipher_valid_q, cipher_valid_d;

    // State, counters and the delayed cipher-valid flag.
    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            state_q        <= S_IDLE;
            round_q        <= '0;
            ad_cnt_q       <= '0;
            pt_cnt_q       <= '0;
            cipher_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            round_q        <= round_d;
            ad_cnt_q       <= ad_cnt_d;
            pt_cnt_q       <= pt_cnt_d;
            cipher_valid_q <= cipher_valid_d;
        end
    end

    // Next state and counters. The round counter is reloaded with the start
    // value of the following permutation when a phase ends, so it holds steady
    // while waiting for data.
    always_comb begin
        state_d        = state_q;
        round_d        = round_q;
        ad_cnt_d       = ad_cnt_q;
        pt_cnt_d       = pt_cnt_q;
        cipher_valid_d = en_cipher_o;
        case (state_q)
            S_IDLE: begin
                round_d  = ROUND_FIRST;
                ad_cnt_d = '0;
                pt_cnt_d = '0;
                if (start_i) state_d = S_INIT;
            end
            S_INIT: begin
                if (round_q == ROUND_LAST) begin
                    round_d = ROUND_HALF;
                    state_d = S_WAIT_AD;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_WAIT_AD: begin
                if (data_valid_i) begin
                    ad_cnt_d = ad_cnt_q + 4'd1;
                    state_d  = S_AD;
                end
            end
            S_AD: begin
                if (round_q == ROUND_LAST) begin
                    round_d = ROUND_HALF;
                    state_d = (ad_cnt_q < NB_AD_L) ? S_WAIT_AD : S_WAIT_PT;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_WAIT_PT: begin
                if (data_valid_i) begin
                    pt_cnt_d = pt_cnt_q + 4'd1;
                    if (pt_cnt_q + 4'd1 == NB_PT_L) begin
                        round_d = ROUND_FIRST;
                        state_d = S_FINAL;
                    end else begin
                        state_d = S_PT;
                    end
                end
            end
            S_PT: begin
                if (round_q == ROUND_LAST) begin
                    round_d = ROUND_HALF;
                    state_d = S_WAIT_PT;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_FINAL: begin
                if (round_q == ROUND_LAST) begin
                    round_d = ROUND_FIRST;
                    state_d = S_DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_DONE: begin
                round_d  = ROUND_FIRST;
                ad_cnt_d = '0;
                pt_cnt_d = '0;
                state_d  = S_IDLE;
            end
            default: begin
                round_d  = '0;
                ad_cnt_d = '0;
                pt_cnt_d = '0;
                state_d  = S_IDLE;
            end
        endcase
`ifdef ASCON_CONTROLLER_ABORT_EN
        if (abort_i && state_q != S_IDLE) begin
            state_d        = S_IDLE;
            round_d        = '0;
            ad_cnt_d       = '0;
            pt_cnt_d       = '0;
            cipher_valid_d = 1'b0;
        end
`endif
    end

    // Datapath controls decoded from the current state and round.
    always_comb begin
        data_ready_o     = 1'b0;
        data_sel_o       = 1'b0;
        en_xor_data_o    = 1'b0;
        en_xor_key_o     = 1'b0;
        en_xor_key_end_o = 1'b0;
        en_xor_lsb_o     = 1'b0;
        en_reg_state_o   = 1'b0;
        en_cipher_o      = 1'b0;
        en_tag_o         = 1'b0;
        done_o           = 1'b0;
        case (state_q)
            S_INIT: begin
                en_reg_state_o   = 1'b1;
                data_sel_o       = (round_q != ROUND_FIRST);
                en_xor_key_end_o = (round_q == ROUND_LAST);
            end
            S_WAIT_AD, S_WAIT_PT: begin
                data_ready_o = 1'b1;
                data_sel_o   = 1'b1;
            end
            S_AD: begin
                en_reg_state_o = 1'b1;
                data_sel_o     = 1'b1;
                en_xor_data_o  = (round_q == ROUND_HALF);
                en_xor_lsb_o   = (round_q == ROUND_LAST) && (ad_cnt_q == NB_AD_L);
            end
            S_PT: begin
                en_reg_state_o = 1'b1;
                data_sel_o     = 1'b1;
                en_xor_data_o  = (round_q == ROUND_HALF);
                en_cipher_o    = (round_q == ROUND_HALF);
            end
            S_FINAL: begin
                en_reg_state_o   = 1'b1;
                data_sel_o       = 1'b1;
                en_xor_data_o    = (round_q == ROUND_FIRST);
                en_cipher_o      = (round_q == ROUND_FIRST);
                en_xor_key_o     = (round_q == ROUND_FIRST);
                en_xor_key_end_o = (round_q == ROUND_LAST);
                en_tag_o         = (round_q == ROUND_LAST);
            end
            S_DONE: begin
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign round_o        = round_q;
    assign cipher_valid_o = cipher_valid_q;

endmodule

// File: tb/tb_ascon_controller.sv
// Directed bench for ascon_controller: two instances (NB_AD=1/NB_PT=4 and
// NB_AD=2/NB_PT=1) share stimulus; a checkpoint table covers the full message,
// followed by hand-written hold, reset and (optionally) abort sequences.
module tb_ascon_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetb, start, valid, abort;

    logic       a_rdy, a_sel, a_xd, a_xk, a_ke, a_lsb, a_rs, a_ci, a_tg, a_cv, a_dn;
    logic [3:0] a_rnd;
    logic       b_rdy, b_sel, b_xd, b_xk, b_ke, b_lsb, b_rs, b_ci, b_tg, b_cv, b_dn;
    logic [3:0] b_rnd;

    ascon_controller #(.NB_AD(1), .NB_PT(4)) u_a (
        .clock_i(clk), .resetb_i(resetb), .start_i(start), .data_valid_i(valid),
`ifdef ASCON_CONTROLLER_ABORT_EN
        .abort_i(abort),
`endif
        .data_ready_o(a_rdy), .round_o(a_rnd), .data_sel_o(a_sel),
        .en_xor_data_o(a_xd), .en_xor_key_o(a_xk), .en_xor_key_end_o(a_ke),
        .en_xor_lsb_o(a_lsb), .en_reg_state_o(a_rs), .en_cipher_o(a_ci),
        .en_tag_o(a_tg), .cipher_valid_o(a_cv), .done_o(a_dn)
    );

    ascon_controller #(.NB_AD(2), .NB_PT(1)) u_b (
        .clock_i(clk), .resetb_i(resetb), .start_i(start), .data_valid_i(valid),
`ifdef ASCON_CONTROLLER_ABORT_EN
        .abort_i(abort),
`endif
        .data_ready_o(b_rdy), .round_o(b_rnd), .data_sel_o(b_sel),
        .en_xor_data_o(b_xd), .en_xor_key_o(b_xk), .en_xor_key_end_o(b_ke),
        .en_xor_lsb_o(b_lsb), .en_reg_state_o(b_rs), .en_cipher_o(b_ci),
        .en_tag_o(b_tg), .cipher_valid_o(b_cv), .done_o(b_dn)
    );

    // Packed order: {ready, round[3:0], sel, xd, xk, key_end, lsb, reg_state, cipher, tag, cipher_valid, done}
    logic [14:0] a_pk, b_pk;
    assign a_pk = {a_rdy, a_rnd, a_sel, a_xd, a_xk, a_ke, a_lsb, a_rs, a_ci, a_tg, a_cv, a_dn};
    assign b_pk = {b_rdy, b_rnd, b_sel, b_xd, b_xk, b_ke, b_lsb, b_rs, b_ci, b_tg, b_cv, b_dn};

    function automatic logic [14:0] ev(input logic rdy, input logic [3:0] rnd,
                                       input logic sel, input logic xd, input logic xk,
                                       input logic ke, input logic lsb, input logic rs,
                                       input logic ci, input logic tg, input logic cv,
                                       input logic dn);
        return {rdy, rnd, sel, xd, xk, ke, lsb, rs, ci, tg, cv, dn};
    endfunction

    typedef struct {
        int          dut;
        int          cyc;
        logic [14:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        start  = 1'b0;
        valid  = 1'b0;
        abort  = 1'b0;
        step();
        step();
        chk("reset_a", {17'd0, a_pk}, 32'd0);
        chk("reset_b", {17'd0, b_pk}, 32'd0);
        resetb = 1'b1;
    endtask

    int cv_a, dn_a, lsb_a, cv_b, dn_b, lsb_b;
    logic seen;

    initial begin
        resetb = 1'b0; start = 1'b0; valid = 1'b0; abort = 1'b0;

        // Full message with data_valid_i held high, start_i also pulsed in AD.
        //                         rdy rnd   sel xd xk ke lsb rs ci tg cv dn
        tbl.push_back('{0,  1, ev(0, 4'd0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "A_init_r0"});
        tbl.push_back('{0,  2, ev(0, 4'd1,  1, 0, 0, 0, 0, 1, 0, 0, 0, 0), "A_init_r1"});
        tbl.push_back('{0, 12, ev(0, 4'd11, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0), "A_init_r11"});
        tbl.push_back('{0, 13, ev(1, 4'd6,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "A_wait_ad"});
        tbl.push_back('{0, 14, ev(0, 4'd6,  1, 1, 0, 0, 0, 1, 0, 0, 0, 0), "A_ad_r6"});
        tbl.push_back('{0, 16, ev(0, 4'd8,  1, 0, 0, 0, 0, 1, 0, 0, 0, 0), "A_ad_r8_start_ignored"});
        tbl.push_back('{0, 19, ev(0, 4'd11, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0), "A_ad_r11_lsb"});
        tbl.push_back('{0, 20, ev(1, 4'd6,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "A_wait_pt1"});
        tbl.push_back('{0, 21, ev(0, 4'd6,  1, 1, 0, 0, 0, 1, 1, 0, 0, 0), "A_pt1_r6"});
        tbl.push_back('{0, 22, ev(0, 4'd7,  1, 0, 0, 0, 0, 1, 0, 0, 1, 0), "A_pt1_cv"});
        tbl.push_back('{0, 26, ev(0, 4'd11, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0), "A_pt1_r11"});
        tbl.push_back('{0, 27, ev(1, 4'd6,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "A_wait_pt2"});
        tbl.push_back('{0, 35, ev(0, 4'd6,  1, 1, 0, 0, 0, 1, 1, 0, 0, 0), "A_pt3_r6"});
        tbl.push_back('{0, 41, ev(1, 4'd6,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "A_wait_pt4"});
        tbl.push_back('{0, 42, ev(0, 4'd0,  1, 1, 1, 0, 0, 1, 1, 0, 0, 0), "A_final_r0"});
        tbl.push_back('{0, 43, ev(0, 4'd1,  1, 0, 0, 0, 0, 1, 0, 0, 1, 0), "A_final_r1"});
        tbl.push_back('{0, 53, ev(0, 4'd11, 1, 0, 0, 1, 0, 1, 0, 1, 0, 0), "A_final_r11"});
        tbl.push_back('{0, 54, ev(0, 4'd0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "A_done"});
        tbl.push_back('{0, 55, ev(0, 4'd0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "A_idle"});
        tbl.push_back('{1, 19, ev(0, 4'd11, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0), "B_ad1_r11_nolsb"});
        tbl.push_back('{1, 20, ev(1, 4'd6,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "B_wait_ad2"});
        tbl.push_back('{1, 21, ev(0, 4'd6,  1, 1, 0, 0, 0, 1, 0, 0, 0, 0), "B_ad2_r6"});
        tbl.push_back('{1, 26, ev(0, 4'd11, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0), "B_ad2_r11_lsb"});
        tbl.push_back('{1, 27, ev(1, 4'd6,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "B_wait_pt"});
        tbl.push_back('{1, 28, ev(0, 4'd0,  1, 1, 1, 0, 0, 1, 1, 0, 0, 0), "B_final_r0"});
        tbl.push_back('{1, 29, ev(0, 4'd1,  1, 0, 0, 0, 0, 1, 0, 0, 1, 0), "B_final_r1"});
        tbl.push_back('{1, 39, ev(0, 4'd11, 1, 0, 0, 1, 0, 1, 0, 1, 0, 0), "B_final_r11"});
        tbl.push_back('{1, 40, ev(0, 4'd0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "B_done"});
        tbl.push_back('{1, 41, ev(0, 4'd0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "B_idle"});

        do_reset();
        cv_a = 0; dn_a = 0; lsb_a = 0; cv_b = 0; dn_b = 0; lsb_b = 0;
        start = 1'b1;
        valid = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            step();
            foreach (tbl[i]) begin
                if (tbl[i].cyc == k)
                    chk(tbl[i].name, {17'd0, (tbl[i].dut == 1) ? b_pk : a_pk}, {17'd0, tbl[i].exp});
            end
            cv_a += int'(a_cv); dn_a += int'(a_dn); lsb_a += int'(a_lsb);
            cv_b += int'(b_cv); dn_b += int'(b_dn); lsb_b += int'(b_lsb);
            start = (k == 15);
            valid = 1'b1;
        end
        chk("A_cv_pulses",  cv_a,  4);
        chk("A_done_pulses", dn_a, 1);
        chk("A_lsb_pulses", lsb_a, 1);
        chk("B_cv_pulses",  cv_b,  1);
        chk("B_done_pulses", dn_b, 1);
        chk("B_lsb_pulses", lsb_b, 1);

        // data_valid_i low for 5 cycles in the first WAIT_PT of instance A.
        do_reset();
        start = 1'b1;
        valid = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k >= 20 && k <= 24) begin
                chk("hold_ready", {31'd0, a_rdy}, 32'd1);
                chk("hold_regst", {31'd0, a_rs},  32'd0);
                chk("hold_round", {28'd0, a_rnd}, 32'd6);
            end
            if (k == 26) chk("hold_resume_pt", {17'd0, a_pk}, {17'd0, ev(0, 4'd6, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0)});
            if (k == 27) chk("hold_resume_cv", {31'd0, a_cv}, 32'd1);
            start = 1'b0;
            valid = (k < 20 || k > 24);
        end
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            step();
            if (a_dn) seen = 1'b1;
        end
        chk("hold_done_reached", {31'd0, seen}, 32'd1);

        // Reset asserted during FINAL round 5, then a clean message.
        do_reset();
        start = 1'b1;
        valid = 1'b1;
        for (int k = 1; k <= 47; k++) begin
            step();
            start = 1'b0;
        end
        chk("rst_final_r5", {17'd0, a_pk}, {17'd0, ev(0, 4'd5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0)});
        resetb = 1'b0;
        step();
        chk("rst_outputs_zero", {17'd0, a_pk}, 32'd0);
        resetb = 1'b1;
        cv_a = 0; dn_a = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            cv_a += int'(a_cv); dn_a += int'(a_dn);
        end
        chk("rst_no_cv",   cv_a, 0);
        chk("rst_no_done", dn_a, 0);
        start = 1'b1;
        cv_a = 0; seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            step();
            start = 1'b0;
            cv_a += int'(a_cv);
            if (a_dn) seen = 1'b1;
        end
        chk("rst_restart_done", {31'd0, seen}, 32'd1);
        chk("rst_restart_cv",   cv_a, 4);

`ifdef ASCON_CONTROLLER_ABORT_EN
        // Abort on PT round 8 of the first plaintext block.
        do_reset();
        start = 1'b1;
        valid = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            step();
            start = 1'b0;
        end
        chk("abort_pt_r8", {28'd0, a_rnd}, 32'd8);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle", {17'd0, a_pk}, 32'd0);
        cv_a = 0; dn_a = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            cv_a += int'(a_cv); dn_a += int'(a_dn);
        end
        chk("abort_no_cv",   cv_a, 0);
        chk("abort_no_done", dn_a, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ascon_controller.md
ASCON_CONTROLLER -- requirements
Module: ascon_controller

Interface
REQ-001 SHALL have parameter NB_AD, default 1, meaning the number of 64-bit associated-data blocks per message (range 1..15).
REQ-002 SHALL have parameter NB_PT, default 4, meaning the number of 64-bit plaintext blocks per message (range 1..15).
REQ-003 SHALL have port clock_i, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port resetb_i, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start_i, input, 1 bit: starts one encryption, sampled only in IDLE.
REQ-006 SHALL have port data_valid_i, input, 1 bit: the datapath data input holds a valid 64-bit block.
REQ-007 SHALL have port data_ready_o, output, 1 bit: the controller can accept a block.
REQ-008 SHALL have port round_o, output, 4 bits: round index driven to the permutation.
REQ-009 SHALL have ports data_sel_o, en_xor_data_o, en_xor_key_o, en_xor_key_end_o, en_xor_lsb_o, en_reg_state_o, en_cipher_o and en_tag_o: outputs, 1 bit each, datapath controls.
REQ-010 SHALL have port cipher_valid_o, output, 1 bit: the cipher register holds a new block.
REQ-011 SHALL have port done_o, output, 1 bit: the tag register is valid and the message is complete.

Function
REQ-012 SHALL implement states IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL and DONE with a 4-bit round counter and 4-bit AD and PT block counters.
REQ-013 SHALL, in IDLE with start_i=1, go to INIT on the next cycle; start_i in any other state SHALL be ignored.
REQ-014 SHALL, in INIT, run 12 cycles with round_o 0..11 and en_reg_state_o=1 on every cycle.
REQ-015 SHALL, in INIT, drive data_sel_o=0 on the round-0 cycle only and data_sel_o=1 on every other active cycle in every state.
REQ-016 SHALL, in INIT, drive en_xor_key_end_o=1 on the round-11 cycle, then go to WAIT_AD.
REQ-017 SHALL, in WAIT_AD and WAIT_PT, drive data_ready_o=1 and en_reg_state_o=0; a transfer occurs on a cycle with data_ready_o=1 and data_valid_i=1.
REQ-018 SHALL, in AD, run 6 cycles with round_o 6..11, drive en_xor_data_o=1 on the first cycle, and drive en_xor_lsb_o=1 on round 11 of AD block NB_AD only.
REQ-019 SHALL, after an AD block, go to WAIT_AD if fewer than NB_AD blocks are done, otherwise to WAIT_PT.
REQ-020 SHALL, in PT (blocks 1..NB_PT-1), run 6 cycles with round_o 6..11 and drive en_xor_data_o=1 and en_cipher_o=1 on the first cycle, then return to WAIT_PT.
REQ-021 SHALL send a transfer of block NB_PT to FINAL, not PT.
REQ-022 SHALL, in FINAL, run 12 cycles with round_o 0..11 and drive en_xor_data_o, en_cipher_o and en_xor_key_o on the first cycle.
REQ-023 SHALL, in FINAL, drive en_xor_key_end_o and en_tag_o on round 11, then go to DONE.
REQ-024 SHALL assert cipher_valid_o for exactly the one cycle after each en_cipher_o cycle.
REQ-025 SHALL, in DONE, assert done_o for exactly one cycle, then return to IDLE.
REQ-026 SHALL drive every control output to 0 wherever this section does not assert it.
REQ-027 SHALL ignore data_valid_i outside WAIT_AD and WAIT_PT, and SHALL never assert data_ready_o in IDLE, INIT, AD, PT, FINAL or DONE.
REQ-028 SHALL wrap the round counter from 11 back to its state's start value with no overflow beyond 11.

Reset
REQ-029 SHALL, with resetb_i=0 at a clock edge, enter IDLE, clear all counters and drive every output to 0 from the next cycle, including mid-operation.
REQ-030 SHALL NOT produce done_o, cipher_valid_o or en_tag_o for a message interrupted by reset.

Configuration
REQ-031 SHALL, with ASCON_CONTROLLER_ABORT_EN defined, add input abort_i (1 bit); abort_i=1 in any non-IDLE state SHALL force IDLE on the next cycle with counters cleared and no done_o.
REQ-032 SHALL, with ASCON_CONTROLLER_ABORT_EN undefined, have no abort_i port, and behaviour SHALL be exactly as in REQ-012..REQ-030.

Verification
REQ-033 SHALL cover: NB_AD=1, NB_PT=4, start at cycle 0, data_valid_i always 1 -> INIT cycles 1-12, AD 14-19, en_xor_lsb_o at 19, three PT bursts, FINAL 12 cycles, done_o pulse once, 4 cipher_valid_o pulses.
REQ-034 SHALL cover: data_valid_i held 0 for 5 cycles in WAIT_PT -> data_ready_o stays 1, en_reg_state_o stays 0, round_o is unchanged, and the sequence resumes on valid.
REQ-035 SHALL cover: NB_AD=2, NB_PT=1 -> en_xor_lsb_o only on the second AD block, and FINAL is entered directly after the first PT transfer with en_xor_key_o=1.
REQ-036 SHALL cover: resetb_i=0 on FINAL round 5 -> all outputs 0 next cycle, then a new start completes normally.
REQ-037 SHALL cover: start_i=1 during AD -> no effect; data_valid_i=1 during INIT -> no transfer counted.
REQ-038 SHALL cover, with ASCON_CONTROLLER_ABORT_EN defined: abort_i=1 on PT round 8 -> IDLE next cycle, no done_o, no further cipher_valid_o.
